// File: rtl/key_debounce_array_pkg.sv
// Shared constants, channel output bundle and parameter width checks for the
// key debounce array.
package key_pkg;

    localparam int KEY_STABLE_20MS_50M = 1_000_000;
    localparam int KEY_LONG_1S_50M     = 50_000_000;

    typedef struct packed {
        logic lvl;
        logic press;
        logic rel;
        logic lng;
        logic led;
    } key_ch_out_t;

    // True when a counter of width w can hold values 0..max_val.
    function automatic bit width_fits(longint max_val, int w);
        return w >= $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_array_ch.sv
// One push-button channel: synchroniser, stability filter, press/release/long
// strobes and a press-toggled LED bit.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = KEY_STABLE_20MS_50M,
    parameter int CNT_W         = 20,
    parameter int LONG_CYCLES   = KEY_LONG_1S_50M,
    parameter int LONG_W        = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        key_raw,
    output key_ch_out_t q
);

    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic              s1, s2, p;
    logic              level, press, rel, lng, led;
    logic [CNT_W-1:0]  cnt;
    logic [LONG_W-1:0] lcnt;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= IDLE_LVL;
            s2 <= IDLE_LVL;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    assign p = s2 ^ IDLE_LVL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            if (p == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                level <= p;
                cnt   <= '0;
                press <= p;
                rel   <= ~p;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // lcnt saturates at LONG_CYCLES, so the strobe can only fire once per press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt <= '0;
            lng  <= 1'b0;
        end else begin
            lng <= level && (lcnt == LONG_W'(LONG_CYCLES - 1));
            if (!level)
                lcnt <= '0;
            else if (lcnt < LONG_W'(LONG_CYCLES))
                lcnt <= lcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led <= 1'b0;
        else if (clr)
            led <= 1'b0;
        else if (press)
            led <= ~led;
    end

    assign q = '{lvl: level, press: press, rel: rel, lng: lng, led: led};

endmodule

// File: rtl/key_debounce_array.sv
// N independent push-button conditioners; each channel is a key_debounce_ch.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS        = 3,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = KEY_STABLE_20MS_50M,
    parameter int CNT_W         = 20,
    parameter int LONG_CYCLES   = KEY_LONG_1S_50M,
    parameter int LONG_W        = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] led
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("key_debounce_array: STABLE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("key_debounce_array: LONG_CYCLES must be >= 1");
    end
    if (!width_fits(STABLE_CYCLES - 1, CNT_W)) begin : g_bad_cnt_w
        $error("key_debounce_array: CNT_W too small for STABLE_CYCLES");
    end
    if (!width_fits(LONG_CYCLES, LONG_W)) begin : g_bad_long_w
        $error("key_debounce_array: LONG_W too small for LONG_CYCLES");
    end

    key_ch_out_t [N_KEYS-1:0] ch_out;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W),
            .LONG_CYCLES  (LONG_CYCLES),
            .LONG_W       (LONG_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .key_raw(key_in[i]),
            .q      (ch_out[i])
        );

        assign key_level[i]   = ch_out[i].lvl;
        assign key_press[i]   = ch_out[i].press;
        assign key_release[i] = ch_out[i].rel;
        assign key_long[i]    = ch_out[i].lng;
        assign led[i]         = ch_out[i].led;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Randomised and directed bench for key_debounce_array with a cycle-level
// reference model feeding an expected-output queue.
module tb_key_debounce_array;

    localparam int N    = 3;
    localparam int STB  = 4;
    localparam int LONG = 16;
    localparam int D    = STB + 2;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] led;
    } out_t;

    logic         clk, rst, clr;
    logic [N-1:0] key_in;
    logic [N-1:0] key_level, key_press, key_release, key_long, led;

    key_debounce_array #(
        .N_KEYS(N), .ACTIVE_LOW(1), .STABLE_CYCLES(STB), .CNT_W(3),
        .LONG_CYCLES(LONG), .LONG_W(5)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .key_in(key_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pc [N];
    int rc [N];
    int lc [N];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference model: a key is accepted once the last STB synchronised samples
    // (each delayed two edges) all disagree with the accepted level.
    out_t   exp_q[$];
    bit     hist  [N][D];
    bit     m_lvl [N];
    bit     m_led [N];
    bit     m_prs [N];
    longint p_edge[N];
    longint edge_n = 0;

    always @(posedge clk) begin
        out_t e;
        bit   diff, was;
        e = '0;
        edge_n++;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                for (int i = 0; i < D; i++) hist[c][i] = 1'b0;
                m_lvl[c] = 1'b0;
                m_led[c] = 1'b0;
                m_prs[c] = 1'b0;
            end else begin
                was = m_lvl[c];
                for (int i = D - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = (key_in[c] == 1'b0);
                diff = 1'b1;
                for (int i = 2; i < D; i++) if (hist[c][i] == m_lvl[c]) diff = 1'b0;
                if (was && (edge_n - p_edge[c] == LONG)) e.lng[c] = 1'b1;
                if (clr) m_led[c] = 1'b0;
                else if (m_prs[c]) m_led[c] = ~m_led[c];
                m_prs[c] = 1'b0;
                if (diff) begin
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) begin
                        m_prs[c]   = 1'b1;
                        p_edge[c]  = edge_n;
                        e.press[c] = 1'b1;
                    end else begin
                        e.rel[c] = 1'b1;
                    end
                end
            end
            e.lvl[c] = m_lvl[c];
            e.led[c] = m_led[c];
        end
        exp_q.push_back(e);
    end

    // Monitor: every cycle presents a full output vector; pop and compare.
    always @(negedge clk) begin
        out_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{lvl: key_level, press: key_press, rel: key_release, lng: key_long, led: led};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b lng=%b led=%b expected lvl=%b prs=%b rel=%b lng=%b led=%b",
                          $time, a.lvl, a.press, a.rel, a.lng, a.led, e.lvl, e.press, e.rel, e.lng, e.led);
        end
        for (int c = 0; c < N; c++) begin
            pc[c] += int'(key_press[c]);
            rc[c] += int'(key_release[c]);
            lc[c] += int'(key_long[c]);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, mode;
        for (int c = 0; c < N; c++) begin
            pc[c] = 0; rc[c] = 0; lc[c] = 0; p_edge[c] = 0;
        end
        rst = 1'b1; clr = 1'b0; key_in = 3'b111;
        tick(3);
        check("reset_outputs", int'({key_level, key_press, key_release, key_long, led}), 0);
        rst = 1'b0;
        tick(50);
        check("idle_strobes", pc[0]+pc[1]+pc[2]+rc[0]+rc[1]+rc[2]+lc[0]+lc[1]+lc[2], 0);

        // Clean press / release / re-press on ch0
        key_in[0] = 1'b0; tick(5);
        check("ch0_press_not_before_edge5", pc[0], 0);
        tick(1);
        check("ch0_press_at_edge5", pc[0], 1);
        tick(6);
        check("ch0_level", int'(key_level[0]), 1);
        check("ch0_led_on", int'(led[0]), 1);
        key_in[0] = 1'b1; tick(12);
        check("ch0_release_cnt", rc[0], 1);
        check("ch0_led_kept", int'(led[0]), 1);
        key_in[0] = 1'b0; tick(12);
        check("ch0_led_off", int'(led[0]), 0);
        key_in[0] = 1'b1; tick(12);

        // Bounce on ch1: 3-cycle toggles never qualify, final hold does
        base = pc[1];
        for (int i = 0; i < 10; i++) begin
            key_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        key_in[1] = 1'b0; tick(5);
        check("bounce_no_early_press", pc[1], base);
        tick(1);
        check("bounce_single_press", pc[1], base + 1);
        tick(10);
        check("bounce_no_release", rc[1], 0);
        key_in[1] = 1'b1; tick(12);

        // Long press on ch2, then a short press that must not produce key_long
        key_in[2] = 1'b0; tick(21);
        check("long_not_early", lc[2], 0);
        tick(1);
        check("long_fires", lc[2], 1);
        tick(18);
        check("long_no_repeat", lc[2], 1);
        key_in[2] = 1'b1; tick(12);
        key_in[2] = 1'b0; tick(15);
        key_in[2] = 1'b1; tick(20);
        check("long_cancelled", lc[2], 1);

        // Simultaneous ch0 + ch2 press
        base = pc[0] + pc[2];
        key_in = 3'b010; tick(12);
        check("simul_presses", pc[0] + pc[2], base + 2);
        key_in = 3'b111; tick(12);

        // clr alone, then clr coincident with key_press[1]
        clr = 1'b1; tick(1); clr = 1'b0; tick(2);
        check("clr_all", int'(led), 0);
        base = pc[1];
        key_in[1] = 1'b0; tick(6);
        check("clr_press_seen", pc[1], base + 1);
        clr = 1'b1; tick(1); clr = 1'b0; tick(2);
        check("clr_beats_press", int'(led[1]), 0);
        key_in[1] = 1'b1; tick(12);

        // Reset mid-count on ch0, key held through reset release
        key_in[0] = 1'b0; tick(4);
        rst = 1'b1; #1;
        check("reset_immediate", int'({key_level, key_press, key_release, key_long, led}), 0);
        tick(2);
        rst = 1'b0;
        base = pc[0];
        tick(5);
        check("rst_repress_not_early", pc[0], base);
        tick(1);
        check("rst_repress_edge5", pc[0], base + 1);
        key_in[0] = 1'b1; tick(12);

        // Random phase: alternate chattery and calm regimes, occasional clr / rst
        mode = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) mode = int'($urandom_range(0, 2));
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, (mode == 0) ? 2 : (mode == 1) ? 8 : 40) == 0)
                    key_in[c] = ~key_in[c];
            end
            clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            tick(1);
        end
        clr = 1'b0;
        tick(5);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
